// File: rtl/serial_sub_ctrl_311_pkg.sv
// serial_sub_pkg_311
//   Shared definitions for the bit-serial subtract controller:
//   FSM state type and encodings, and the maximum supported operand width.
package serial_sub_pkg_311;

    // Upper bound on the WIDTH parameter of serial_sub_ctrl_311.
    localparam int SS_MAX_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/serial_sub_ctrl_311_fs.sv
// fs_311
//   One-bit full-subtractor cell: computes x - y - z.
//   Ports:
//     x_311 in  : minuend bit
//     y_311 in  : subtrahend bit
//     z_311 in  : borrow-in
//     d_311 out : difference bit
//     b_311 out : borrow-out
module fs_311 (
    input  logic x_311,
    input  logic y_311,
    input  logic z_311,
    output logic d_311,
    output logic b_311
);

    assign d_311 = x_311 ^ y_311 ^ z_311;
    // Borrow when y exceeds x, or when x == y and a borrow comes in.
    assign b_311 = (~x_311 & y_311) | (~(x_311 ^ y_311) & z_311);

endmodule

// File: rtl/serial_sub_ctrl_311.sv
// serial_sub_ctrl_311
//   Bit-serial N-bit subtractor controller: computes A - B - Bin by stepping
//   a single fs_311 cell over the operands LSB-first, one bit per clock.
//   Optional feature macro: SERIAL_SUB_OVF_EN (adds ovf_311 signed overflow).
//   Ports:
//     clk_311   in  : clock, rising edge
//     rst_n_311 in  : asynchronous active-low reset
//     start_311 in  : request, sampled only in IDLE
//     a_311     in  : minuend, captured on acceptance
//     b_311     in  : subtrahend, captured on acceptance
//     bin_311   in  : borrow-in, captured on acceptance
//     busy_311  out : high while an operation is in flight (RUN/DONE)
//     done_311  out : one-cycle pulse, result valid
//     diff_311  out : difference (shift register, final at done_311)
//     bout_311  out : final borrow-out
//     ovf_311   out : signed overflow (only with SERIAL_SUB_OVF_EN)
module serial_sub_ctrl_311
    import serial_sub_pkg_311::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_311,
    input  logic             rst_n_311,
    input  logic             start_311,
    input  logic [WIDTH-1:0] a_311,
    input  logic [WIDTH-1:0] b_311,
    input  logic             bin_311,
    output logic             busy_311,
    output logic             done_311,
    output logic [WIDTH-1:0] diff_311,
    output logic             bout_311
`ifdef SERIAL_SUB_OVF_EN
   ,output logic             ovf_311
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic cell_d;
    logic cell_b;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits kept from acceptance; the shifters lose them.
    logic amsb_q, amsb_d;
    logic bmsb_q, bmsb_d;
    logic ovf_q, ovf_d;
`endif

    fs_311 u_fs (
        .x_311 (sa_q[0]),
        .y_311 (sb_q[0]),
        .z_311 (brw_q),
        .d_311 (cell_d),
        .b_311 (cell_b)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        // Registered from the current state so busy/done lag the FSM by one
        // edge: busy covers RUN+DONE, done marks the edge leaving DONE.
        busy_d  = (state_q != ST_IDLE);
        done_d  = (state_q == ST_DONE);
`ifdef SERIAL_SUB_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_311) begin
                    sa_d    = a_311;
                    sb_d    = b_311;
                    brw_d   = bin_311;
                    cnt_d   = '0;
                    diff_d  = '0;
`ifdef SERIAL_SUB_OVF_EN
                    amsb_d  = a_311[WIDTH-1];
                    bmsb_d  = b_311[WIDTH-1];
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                diff_d = {cell_d, diff_q[WIDTH-1:1]};
                brw_d  = cell_b;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bout_d  = brw_q;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d   = (amsb_q != bmsb_q) && (diff_q[WIDTH-1] != amsb_q);
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_311 or negedge rst_n_311) begin
        if (!rst_n_311) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy_311 = busy_q;
    assign done_311 = done_q;
    assign diff_311 = diff_q;
    assign bout_311 = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf_311  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl_311.sv
// tb_serial_sub_ctrl_311
//   Self-checking bench for serial_sub_ctrl_311 (WIDTH=8). Expected results
//   come from plain integer arithmetic on the operands.
module tb_serial_sub_ctrl_311;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_sub_ctrl_311 #(.WIDTH(W)) dut (
        .clk_311   (clk),
        .rst_n_311 (rst_n),
        .start_311 (start),
        .a_311     (a),
        .b_311     (b),
        .bin_311   (bin),
        .busy_311  (busy),
        .done_311  (done),
        .diff_311  (diff),
        .bout_311  (bout)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf_311   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model.
    function automatic logic [W-1:0] ref_diff(input int unsigned x, input int unsigned y, input int unsigned z);
        int unsigned r;
        r = (x + 256 - y - z) % 256;
        return r[W-1:0];
    endfunction

    function automatic logic ref_bout(input int unsigned x, input int unsigned y, input int unsigned z);
        return (x < y + z);
    endfunction

    function automatic logic ref_ovf(input int unsigned x, input int unsigned y, input int unsigned z);
        int sx, sy, sd;
        sx = (x >= 128) ? int'(x) - 256 : int'(x);
        sy = (y >= 128) ? int'(y) - 256 : int'(y);
        sd = sx - sy - int'(z);
        return (sd > 127) || (sd < -128);
    endfunction

    // Drives one request from IDLE and observes 12 cycles after acceptance.
    logic [W-1:0] obs_diff;
    logic         obs_bout;
    logic         obs_ovf;
    int           obs_lat, obs_busy, obs_done;

    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin);
        a = xa; b = xb; bin = xbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        obs_lat = -1; obs_busy = 0; obs_done = 0;
        obs_diff = 'x; obs_bout = 1'bx; obs_ovf = 1'bx;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (busy) obs_busy++;
            if (done) begin
                obs_done++;
                if (obs_lat < 0) begin
                    obs_lat  = i;
                    obs_diff = diff;
                    obs_bout = bout;
`ifdef SERIAL_SUB_OVF_EN
                    obs_ovf  = ovf;
`endif
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (diff !== '0)   begin n_err++; $display("FAIL reset_diff got=%h exp=00", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL reset_bout got=%b exp=0", bout); end
`ifdef SERIAL_SUB_OVF_EN
        n_cmp++; if (ovf !== 1'b0)  begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_op(8'h5A, 8'h3C, 1'b0);
        n_cmp++; if (obs_diff !== 8'h1E) begin n_err++; $display("FAIL basic_diff got=%h exp=1e", obs_diff); end
        n_cmp++; if (obs_bout !== 1'b0)  begin n_err++; $display("FAIL basic_bout got=%b exp=0", obs_bout); end
        n_cmp++; if (obs_lat !== 9)      begin n_err++; $display("FAIL basic_latency got=%0d exp=9", obs_lat); end
        n_cmp++; if (obs_busy !== 9)     begin n_err++; $display("FAIL basic_busy_cycles got=%0d exp=9", obs_busy); end
        n_cmp++; if (obs_done !== 1)     begin n_err++; $display("FAIL basic_done_count got=%0d exp=1", obs_done); end
    endtask

    task automatic test_borrow();
        do_op(8'h00, 8'h01, 1'b0);
        n_cmp++; if (obs_diff !== 8'hFF) begin n_err++; $display("FAIL borrow1_diff got=%h exp=ff", obs_diff); end
        n_cmp++; if (obs_bout !== 1'b1)  begin n_err++; $display("FAIL borrow1_bout got=%b exp=1", obs_bout); end
        do_op(8'h10, 8'h10, 1'b1);
        n_cmp++; if (obs_diff !== 8'hFF) begin n_err++; $display("FAIL borrow2_diff got=%h exp=ff", obs_diff); end
        n_cmp++; if (obs_bout !== 1'b1)  begin n_err++; $display("FAIL borrow2_bout got=%b exp=1", obs_bout); end
`ifdef SERIAL_SUB_OVF_EN
        do_op(8'h80, 8'h01, 1'b0);
        n_cmp++; if (obs_diff !== 8'h7F) begin n_err++; $display("FAIL ovf1_diff got=%h exp=7f", obs_diff); end
        n_cmp++; if (obs_ovf !== 1'b1)   begin n_err++; $display("FAIL ovf1_ovf got=%b exp=1", obs_ovf); end
        do_op(8'h05, 8'h03, 1'b0);
        n_cmp++; if (obs_ovf !== 1'b0)   begin n_err++; $display("FAIL ovf2_ovf got=%b exp=0", obs_ovf); end
`endif
    endtask

    task automatic test_random();
        int unsigned ra, rb, rc;
        for (int n = 0; n < 24; n++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            rc = $urandom_range(0, 1);
            do_op(ra[W-1:0], rb[W-1:0], rc[0]);
            n_cmp++;
            if (obs_diff !== ref_diff(ra, rb, rc) || obs_bout !== ref_bout(ra, rb, rc) || obs_lat !== 9) begin
                n_err++;
                $display("FAIL random_op a=%h b=%h bin=%0d got diff=%h bout=%b lat=%0d exp diff=%h bout=%b lat=9",
                         ra, rb, rc, obs_diff, obs_bout, obs_lat, ref_diff(ra, rb, rc), ref_bout(ra, rb, rc));
            end
`ifdef SERIAL_SUB_OVF_EN
            n_cmp++;
            if (obs_ovf !== ref_ovf(ra, rb, rc)) begin
                n_err++;
                $display("FAIL random_ovf a=%h b=%h bin=%0d got=%b exp=%b", ra, rb, rc, obs_ovf, ref_ovf(ra, rb, rc));
            end
`endif
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        logic [W-1:0] d_at_done;
        dones = 0; d_at_done = '0;
        a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (done) begin dones++; d_at_done = diff; end
            if (i == 3) begin a = 8'hFF; b = 8'h00; start = 1'b1; end
            else if (i == 4) start = 1'b0;
        end
        n_cmp++; if (dones !== 1)        begin n_err++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
        n_cmp++; if (d_at_done !== 8'h22) begin n_err++; $display("FAIL ignore_diff got=%h exp=22", d_at_done); end
        n_cmp++; if (diff !== 8'h22)     begin n_err++; $display("FAIL ignore_diff_hold got=%h exp=22", diff); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL ignore_busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_cmp++; if (diff !== '0)   begin n_err++; $display("FAIL midrst_diff got=%h exp=00", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL midrst_bout got=%b exp=0", bout); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
        do_op(8'h07, 8'h02, 1'b0);
        n_cmp++; if (obs_diff !== 8'h05) begin n_err++; $display("FAIL midrst_fresh_diff got=%h exp=05", obs_diff); end
    endtask

    task automatic test_back_to_back();
        int unsigned ca, cb;
        int dones, last;
        dones = 0; last = -1;
        ca = $urandom_range(0, 255); cb = $urandom_range(0, 255);
        a = ca[W-1:0]; b = cb[W-1:0]; bin = 1'b0; start = 1'b1;
        for (int t = 0; t < 60 && dones < 4; t++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                n_cmp++;
                if (diff !== ref_diff(ca, cb, 0) || bout !== ref_bout(ca, cb, 0)) begin
                    n_err++;
                    $display("FAIL b2b_result a=%h b=%h got diff=%h bout=%b exp diff=%h bout=%b",
                             ca, cb, diff, bout, ref_diff(ca, cb, 0), ref_bout(ca, cb, 0));
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (t - last !== 10) begin n_err++; $display("FAIL b2b_spacing got=%0d exp=10", t - last); end
                end
                last = t;
                ca = $urandom_range(0, 255); cb = $urandom_range(0, 255);
                a = ca[W-1:0]; b = cb[W-1:0];
            end
        end
        n_cmp++; if (dones !== 4) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=4", dones); end
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
